// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module     : ps2_pkg
// Description: Shared constants for the PS/2 receiver. Holds the frame
//              geometry and the receive FSM state encoding.
// Revision   : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Frame: start + 8 data + parity + stop
  localparam int c_frame_len = 11;
  localparam int c_data_w    = 8;
  // The start bit is consumed on entry, so the rest of the frame is shifted
  localparam int c_shift_w   = c_frame_len - 1;
  localparam int c_bitcnt_w  = $clog2(c_shift_w);

  // Receive FSM encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_dps  = 2'd1;
  localparam logic [1:0] c_st_load = 2'd2;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ============================================================================
// Module     : ps2_clk_filter
// Description: Brings ps2_clk / ps2_data into the clk domain through 2-flop
//              synchronizers, debounces ps2_clk and flags its falling edges.
// Ports      : clk        - system clock (rising edge)
//              reset      - asynchronous active-low reset
//              ps2_clk    - raw PS/2 clock
//              ps2_data   - raw PS/2 data
//              clk_level  - filtered PS/2 clock level
//              fall_edge  - one-cycle pulse when clk_level goes 1->0
//              data_sync  - synchronized PS/2 data
// Revision   : 1.0 - initial release
// ============================================================================
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_level,
  output logic fall_edge,
  output logic data_sync
);

  localparam int                c_cnt_w    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

  logic [1:0]         r_clk_sync;
  logic [1:0]         r_data_sync;
  logic               r_level;
  logic               r_fall;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_clk_s;

  assign w_clk_s = r_clk_sync[1];

  // Idle PS/2 lines are high, so the synchronizers reset to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // r_cnt counts consecutive samples that disagree with the current level;
  // the level flips on the FILTER_LEN-th such sample. The edge pulse is
  // registered alongside so it coincides with the first cycle of the new level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= w_clk_s;
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign clk_level = r_level;
  assign fall_edge = r_fall;
  assign data_sync = r_data_sync[1];

endmodule : ps2_clk_filter
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module     : ps2_rx
// Description: PS/2 frame receiver. Collects start/8 data/odd parity/stop
//              on filtered ps2_clk falling edges, presents the byte with
//              parity and framing flags, and aborts stalled frames.
// Ports      : clk          - system clock (rising edge)
//              reset        - asynchronous active-low reset
//              ps2_clk      - raw PS/2 clock
//              ps2_data     - raw PS/2 data
//              rx_en        - accept new frames when high
//              dout         - last received data byte
//              rx_done_tick - one-cycle strobe, dout/flags valid
//              parity_err   - odd-parity failure for the byte on dout
//              frame_err    - stop bit was low for the byte on dout
//              timeout_tick - one-cycle strobe when a frame is aborted
// Revision   : 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick
);

  import ps2_pkg::*;

  localparam int                   c_wd_w      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_wd_w-1:0]     c_wd_last   = c_wd_w'(TIMEOUT_CYC - 1);
  localparam logic [c_bitcnt_w-1:0] c_bits_load = c_bitcnt_w'(c_shift_w - 1);

  logic                  w_clk_level;
  logic                  w_fall;
  logic                  w_data;
  logic                  w_timeout;
  logic [c_shift_w-1:0]  w_shift_next;

  logic [1:0]            r_state;
  logic [c_bitcnt_w-1:0] r_bitcnt;
  logic [c_wd_w-1:0]     r_wdog;
  logic [c_shift_w-1:0]  r_shift;
  logic [c_data_w-1:0]   r_dout;
  logic                  r_perr;
  logic                  r_ferr;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_level (w_clk_level),
    .fall_edge (w_fall),
    .data_sync (w_data)
  );

  // Stalled-frame detection has priority over any edge in the same cycle
  assign w_timeout    = (r_state == c_st_dps) && (r_wdog == c_wd_last);
  // Right shift: first bit received ends up in the LSB after the stop bit
  assign w_shift_next = {w_data, r_shift[c_shift_w-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_st_idle;
      r_bitcnt <= '0;
      r_wdog   <= '0;
      r_shift  <= '0;
      r_dout   <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          // Start bit: low data on a settled low clock while enabled
          if (w_fall && !w_clk_level && !w_data && rx_en) begin
            r_state  <= c_st_dps;
            r_bitcnt <= c_bits_load;
            r_shift  <= '0;
            r_wdog   <= '0;
          end
        end
        c_st_dps: begin
          if (w_timeout) begin
            r_state <= c_st_idle;
            r_wdog  <= '0;
          end else if (w_fall) begin
            r_shift <= w_shift_next;
            r_wdog  <= '0;
            if (r_bitcnt == '0) begin
              // Result registers load on the stop-bit edge so they are
              // already stable during the LOAD cycle when the strobe is high.
              r_state <= c_st_load;
              r_dout  <= w_shift_next[c_data_w-1:0];
              r_perr  <= ~^w_shift_next[c_data_w:0];
              r_ferr  <= ~w_shift_next[c_shift_w-1];
            end else begin
              r_bitcnt <= r_bitcnt - c_bitcnt_w'(1);
            end
          end else begin
            r_wdog <= r_wdog + c_wd_w'(1);
          end
        end
        c_st_load: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign parity_err   = r_perr;
  assign frame_err    = r_ferr;
  assign rx_done_tick = (r_state == c_st_load);
  assign timeout_tick = w_timeout;

endmodule : ps2_rx
`default_nettype wire
